// File: rtl/tx_packet_framer.sv
// tx_packet_framer: collects 16-bit result words into a buffer, then sends them to the UART TX
// as a sync byte, a header, the data bytes MSB-first and an XOR checksum.
module tx_packet_framer #(
    parameter logic [7:0] SYNC_BYTE       = 8'hA5,
    parameter int         MAX_WORDS       = 15,
    parameter int         COLLECT_TIMEOUT = 1024
) (
    input  logic        i_Clk,
    input  logic        i_Rst_n,
    input  logic [15:0] i_Tx_Word,
    input  logic        i_Write_Tx_Word,
    input  logic [3:0]  i_Tx_Word_Cnt,
    input  logic [3:0]  i_Tx_Resp_Type,
    output logic [7:0]  o_Tx_Byte,
    output logic        o_Tx_DV,
    input  logic        i_Tx_Active,
    input  logic        i_Tx_Done,
    output logic        o_Busy,
    output logic        o_Pkt_Done,
    output logic        o_Err
);
    localparam int TW = $clog2(COLLECT_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE, COLLECT, SEND_SYNC, SEND_HDR, SEND_HI, SEND_LO, SEND_CSUM, WAIT_DONE
    } state_t;

    state_t        state, state_n, ret, ret_n;
    logic [15:0]   word_buf [0:MAX_WORDS-1];
    logic [3:0]    wr_idx, wr_idx_n, rd_idx, rd_idx_n, cnt, cnt_n, typ, typ_n, wr_addr;
    logic [7:0]    csum, csum_n, byte_n, tx_b;
    logic [TW-1:0] timer, timer_n;
    logic          dv_n, done_n, err_n, wr_en;

    assign o_Busy  = !(state == IDLE || state == COLLECT);
    assign wr_addr = (state == IDLE) ? 4'd0 : wr_idx;

    // Next-state and datapath decisions; a send state issues its byte only once the UART is idle
    always_comb begin
        state_n  = state;
        ret_n    = ret;
        wr_idx_n = wr_idx;
        rd_idx_n = rd_idx;
        cnt_n    = cnt;
        typ_n    = typ;
        csum_n   = csum;
        timer_n  = timer;
        byte_n   = o_Tx_Byte;
        dv_n     = 1'b0;
        done_n   = 1'b0;
        err_n    = 1'b0;
        wr_en    = 1'b0;
        tx_b     = (state == SEND_SYNC) ? SYNC_BYTE :
                   (state == SEND_HDR)  ? {typ, cnt} :
                   (state == SEND_HI)   ? word_buf[rd_idx][15:8] :
                   (state == SEND_LO)   ? word_buf[rd_idx][7:0] : csum;
        case (state)
            IDLE: if (i_Write_Tx_Word) begin
                err_n = (i_Tx_Word_Cnt == 4'd0);
                if (!err_n) begin
                    wr_en    = 1'b1;
                    cnt_n    = i_Tx_Word_Cnt;
                    typ_n    = i_Tx_Resp_Type;
                    wr_idx_n = 4'd1;
                    rd_idx_n = 4'd0;
                    csum_n   = 8'd0;
                    timer_n  = '0;
                    state_n  = (i_Tx_Word_Cnt == 4'd1) ? SEND_SYNC : COLLECT;
                end
            end
            COLLECT: if (i_Write_Tx_Word) begin
                wr_en    = 1'b1;
                wr_idx_n = wr_idx + 4'd1;
                timer_n  = '0;
                if (wr_idx + 4'd1 == cnt) state_n = SEND_SYNC;
            end else if (timer == TW'(COLLECT_TIMEOUT - 1)) begin
                err_n   = 1'b1;
                timer_n = '0;
                state_n = IDLE;
            end else begin
                timer_n = timer + 1'b1;
            end
            WAIT_DONE: if (i_Tx_Done) begin
                state_n = ret;
                done_n  = (ret == IDLE);
            end
            default: if (!i_Tx_Active) begin
                byte_n   = tx_b;
                dv_n     = 1'b1;
                state_n  = WAIT_DONE;
                csum_n   = (state == SEND_SYNC || state == SEND_CSUM) ? csum : csum ^ tx_b;
                rd_idx_n = (state == SEND_LO) ? rd_idx + 4'd1 : rd_idx;
                ret_n    = (state == SEND_SYNC) ? SEND_HDR :
                           (state == SEND_HI)   ? SEND_LO :
                           (state == SEND_CSUM) ? IDLE :
                           (state == SEND_LO && rd_idx + 4'd1 == cnt) ? SEND_CSUM : SEND_HI;
            end
        endcase
        if (i_Write_Tx_Word && o_Busy) err_n = 1'b1;
    end

    // State, control registers and registered UART-side outputs
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state      <= IDLE;
            ret        <= IDLE;
            wr_idx     <= 4'd0;
            rd_idx     <= 4'd0;
            cnt        <= 4'd0;
            typ        <= 4'd0;
            csum       <= 8'd0;
            timer      <= '0;
            o_Tx_Byte  <= 8'd0;
            o_Tx_DV    <= 1'b0;
            o_Pkt_Done <= 1'b0;
            o_Err      <= 1'b0;
        end else begin
            state      <= state_n;
            ret        <= ret_n;
            wr_idx     <= wr_idx_n;
            rd_idx     <= rd_idx_n;
            cnt        <= cnt_n;
            typ        <= typ_n;
            csum       <= csum_n;
            timer      <= timer_n;
            o_Tx_Byte  <= byte_n;
            o_Tx_DV    <= dv_n;
            o_Pkt_Done <= done_n;
            o_Err      <= err_n;
        end
    end

    // Word buffer storage; stale contents are simply never read once a packet is discarded
    always_ff @(posedge i_Clk) begin
        if (wr_en) word_buf[wr_addr] <= i_Tx_Word;
    end
endmodule

// File: tb/tb_tx_packet_framer.sv
// tb_tx_packet_framer: directed checks of the packet framer against a simple UART TX responder.
module tb_tx_packet_framer;
    logic        i_Clk = 1'b0;
    logic        i_Rst_n = 1'b0;
    logic [15:0] i_Tx_Word = '0;
    logic        i_Write_Tx_Word = 1'b0;
    logic [3:0]  i_Tx_Word_Cnt = '0;
    logic [3:0]  i_Tx_Resp_Type = '0;
    logic        i_Tx_Active = 1'b0;
    logic        i_Tx_Done = 1'b0;
    logic [7:0]  o_Tx_Byte;
    logic        o_Tx_DV, o_Busy, o_Pkt_Done, o_Err;

    int checks = 0, failures = 0, errs = 0, pkts = 0, ucnt = 0;
    int e0, p0, n0;
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];

    always #5 i_Clk = ~i_Clk;

    tx_packet_framer dut (
        .i_Clk(i_Clk), .i_Rst_n(i_Rst_n), .i_Tx_Word(i_Tx_Word),
        .i_Write_Tx_Word(i_Write_Tx_Word), .i_Tx_Word_Cnt(i_Tx_Word_Cnt),
        .i_Tx_Resp_Type(i_Tx_Resp_Type), .o_Tx_Byte(o_Tx_Byte), .o_Tx_DV(o_Tx_DV),
        .i_Tx_Active(i_Tx_Active), .i_Tx_Done(i_Tx_Done), .o_Busy(o_Busy),
        .o_Pkt_Done(o_Pkt_Done), .o_Err(o_Err)
    );

    // UART model (busy 10 cycles after each byte, then a Done pulse) and output monitor
    always @(negedge i_Clk) begin
        i_Tx_Done = 1'b0;
        if (o_Tx_DV) begin
            rx_q.push_back(o_Tx_Byte);
            i_Tx_Active = 1'b1;
            ucnt = 10;
        end else if (ucnt != 0) begin
            ucnt--;
            if (ucnt == 0) begin
                i_Tx_Active = 1'b0;
                i_Tx_Done = 1'b1;
            end
        end
        if (o_Err) errs++;
        if (o_Pkt_Done) pkts++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [15:0] w, input logic [3:0] c, input logic [3:0] t);
        i_Write_Tx_Word = 1'b1;
        i_Tx_Word = w;
        i_Tx_Word_Cnt = c;
        i_Tx_Resp_Type = t;
        @(negedge i_Clk);
        i_Write_Tx_Word = 1'b0;
    endtask

    task automatic wait_pkts(input int n);
        int k = 0;
        while (pkts < n && k < 3000) begin
            @(negedge i_Clk);
            k++;
        end
        check("pkt_count", pkts, n);
    endtask

    task automatic wait_bytes(input int n);
        int k = 0;
        while (rx_q.size() < n && k < 1000) begin
            @(negedge i_Clk);
            k++;
        end
        check("byte_wait", {31'd0, rx_q.size() >= n}, 32'd1);
    endtask

    task automatic check_stream(input string tag);
        check({tag, "_len"}, rx_q.size(), exp_q.size());
        foreach (exp_q[i])
            check($sformatf("%s[%0d]", tag, i),
                  (i < rx_q.size()) ? {24'd0, rx_q[i]} : 32'hFFFF_FFFF, {24'd0, exp_q[i]});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge i_Clk);
        check("rst_byte", o_Tx_Byte, 0);
        check("rst_dv", o_Tx_DV, 0);
        check("rst_busy", o_Busy, 0);
        check("rst_pkt_done", o_Pkt_Done, 0);
        check("rst_err", o_Err, 0);
        i_Rst_n = 1'b1;
        repeat (2) @(negedge i_Clk);

        // Comm-loop packet
        rx_q.delete();
        exp_q = {8'hA5, 8'h03, 8'h12, 8'h34, 8'h56, 8'h78, 8'h00, 8'h5A, 8'h51};
        wr(16'h1234, 3, 0);
        wr(16'h5678, 3, 0);
        wr(16'h005A, 3, 0);
        wait_pkts(1);
        check_stream("comm");
        check("comm_err", errs, 0);
        @(negedge i_Clk);
        check("comm_busy_end", o_Busy, 0);

        // Single word with latency check
        repeat (3) @(negedge i_Clk);
        rx_q.delete();
        exp_q = {8'hA5, 8'h21, 8'hBE, 8'hEF, 8'h70};
        wr(16'hBEEF, 1, 2);
        check("single_pre_dv", o_Tx_DV, 0);
        check("single_busy", o_Busy, 1);
        @(negedge i_Clk);
        check("single_lat_dv", o_Tx_DV, 1);
        check("single_lat_byte", o_Tx_Byte, 8'hA5);
        wait_pkts(2);
        check_stream("single");

        // Collect timeout
        repeat (3) @(negedge i_Clk);
        rx_q.delete();
        e0 = errs;
        wr(16'h0001, 3, 0);
        wr(16'h0002, 3, 0);
        repeat (1000) @(negedge i_Clk);
        check("tmo_early_err", errs, e0);
        repeat (30) @(negedge i_Clk);
        check("tmo_err", errs, e0 + 1);
        check("tmo_no_bytes", rx_q.size(), 0);
        check("tmo_busy", o_Busy, 0);
        exp_q = {8'hA5, 8'h21, 8'hBE, 8'hEF, 8'h70};
        wr(16'hBEEF, 1, 2);
        @(negedge i_Clk);
        check("tmo_next_lat_dv", o_Tx_DV, 1);
        wait_pkts(3);
        check_stream("tmo_next");

        // Write during send
        repeat (3) @(negedge i_Clk);
        rx_q.delete();
        e0 = errs;
        exp_q = {8'hA5, 8'h03, 8'h12, 8'h34, 8'h56, 8'h78, 8'h00, 8'h5A, 8'h51};
        wr(16'h1234, 3, 0);
        wr(16'h5678, 3, 0);
        wr(16'h005A, 3, 0);
        wait_bytes(2);
        wr(16'hFFFF, 1, 0);
        wait_pkts(4);
        check_stream("wds");
        check("wds_err", errs, e0 + 1);

        // Zero count
        repeat (3) @(negedge i_Clk);
        rx_q.delete();
        e0 = errs;
        wr(16'h1111, 0, 3);
        repeat (20) @(negedge i_Clk);
        check("zero_err", errs, e0 + 1);
        check("zero_no_bytes", rx_q.size(), 0);
        check("zero_busy", o_Busy, 0);

        // Reset during data bytes
        rx_q.delete();
        p0 = pkts;
        wr(16'h1234, 3, 0);
        wr(16'h5678, 3, 0);
        wr(16'h005A, 3, 0);
        wait_bytes(4);
        i_Rst_n = 1'b0;
        #1;
        check("mrst_byte", o_Tx_Byte, 0);
        check("mrst_dv", o_Tx_DV, 0);
        check("mrst_busy", o_Busy, 0);
        check("mrst_pkt_done", o_Pkt_Done, 0);
        check("mrst_err", o_Err, 0);
        n0 = rx_q.size();
        repeat (3) @(negedge i_Clk);
        i_Rst_n = 1'b1;
        repeat (200) @(negedge i_Clk);
        check("mrst_no_more_bytes", rx_q.size(), n0);
        check("mrst_no_pkt", pkts, p0);

        // Back-to-back packets
        rx_q.delete();
        p0 = pkts;
        e0 = errs;
        exp_q = {8'hA5, 8'h03, 8'h12, 8'h34, 8'h56, 8'h78, 8'h00, 8'h5A, 8'h51,
                 8'hA5, 8'h12, 8'hA0, 8'hB1, 8'h0C, 8'h0D, 8'h02};
        wr(16'h1234, 3, 0);
        wr(16'h5678, 3, 0);
        wr(16'h005A, 3, 0);
        for (int k = 0; k < 2000 && !o_Pkt_Done; k++) @(negedge i_Clk);
        check("b2b_done_seen", o_Pkt_Done, 1);
        wr(16'hA0B1, 2, 1);
        wr(16'h0C0D, 2, 1);
        wait_pkts(p0 + 2);
        check_stream("b2b");
        check("b2b_err", errs, e0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
